rs_age_param: RTL

- Parametrised reservation station for the out-of-order core; sits between decoder/rename and the ALU.
- Holds up to DEPTH renamed ALU ops and snoops NCDB result broadcast channels (ALU, LSB, ROB, ...) to wake up source operands.
- Issues the oldest ready op to the ALU over a valid/ready handshake.
- Improvements:
  - Both operands can wake independently in the same cycle.
  - Dispatch-time bypass captures a same-cycle broadcast.
  - Issue is oldest-first, not lowest-index.

---
 rtl/rs_age_param_pkg.sv | 26 ++
 rtl/rs_age_param_if.sv | 52 +++++
 rtl/rs_age_param_age_select.sv | 44 ++++
 rtl/rs_age_param.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rs_age_param_pkg.sv
// Shared types and default widths for the ALU reservation station.
// rs_entry_t is the entry layout at the default widths. The top-level module
// declares the same layout with its own parameter widths.
package rs_age_param_pkg;
  localparam int RS_DEPTH  = 16;
  localparam int RS_NCDB   = 3;
  localparam int RS_TAG_W  = 4;
  localparam int RS_DATA_W = 32;
  localparam int RS_OP_W   = 6;
  localparam int RS_IMM_W  = 32;
  localparam int RS_PC_W   = 32;

  typedef struct packed {
    logic                 busy;
    logic [RS_OP_W-1:0]   op;
    logic                 rs1_wait;
    logic [RS_TAG_W-1:0]  rs1_tag;
    logic [RS_DATA_W-1:0] rs1_val;
    logic                 rs2_wait;
    logic [RS_TAG_W-1:0]  rs2_tag;
    logic [RS_DATA_W-1:0] rs2_val;
    logic [RS_TAG_W-1:0]  rd_tag;
    logic [RS_IMM_W-1:0]  imm;
    logic [RS_PC_W-1:0]   pc;
  } rs_entry_t;
endpackage

// File: rtl/rs_age_param_if.sv
// Interface: the reservation station's bus bundle.
// It carries control (rdy, flush), dispatch, the NCDB broadcast channels,
// the issue handshake, and status (rs_full, rs_count).
// master = decoder/CDB/ALU side, slave = reservation station.
interface rs_age_param_if
  import rs_age_param_pkg::*;
#(
  parameter int DEPTH  = RS_DEPTH,
  parameter int NCDB   = RS_NCDB,
  parameter int TAG_W  = RS_TAG_W,
  parameter int DATA_W = RS_DATA_W,
  parameter int OP_W   = RS_OP_W,
  parameter int IMM_W  = RS_IMM_W,
  parameter int PC_W   = RS_PC_W
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                   rdy, flush;
  logic                   disp_valid, disp_ready;
  logic                   disp_rs1_wait, disp_rs2_wait;
  logic [TAG_W-1:0]       disp_rs1_tag, disp_rs2_tag, disp_rd_tag;
  logic [DATA_W-1:0]      disp_rs1_val, disp_rs2_val;
  logic [OP_W-1:0]        disp_op;
  logic [IMM_W-1:0]       disp_imm;
  logic [PC_W-1:0]        disp_pc;
  logic [NCDB-1:0]        cdb_valid;
  logic [NCDB*TAG_W-1:0]  cdb_tag;
  logic [NCDB*DATA_W-1:0] cdb_val;
  logic                   iss_valid, iss_ready;
  logic [OP_W-1:0]        iss_op;
  logic [DATA_W-1:0]      iss_rs1_val, iss_rs2_val;
  logic [IMM_W-1:0]       iss_imm;
  logic [PC_W-1:0]        iss_pc;
  logic [TAG_W-1:0]       iss_rd_tag;
  logic                   rs_full;
  logic [CNT_W-1:0]       rs_count;

  modport master (
    output rdy, flush, disp_valid, disp_rs1_wait, disp_rs1_tag, disp_rs1_val,
           disp_rs2_wait, disp_rs2_tag, disp_rs2_val, disp_rd_tag, disp_op,
           disp_imm, disp_pc, cdb_valid, cdb_tag, cdb_val, iss_ready,
    input  disp_ready, iss_valid, iss_op, iss_rs1_val, iss_rs2_val, iss_imm,
           iss_pc, iss_rd_tag, rs_full, rs_count
  );
  modport slave (
    input  rdy, flush, disp_valid, disp_rs1_wait, disp_rs1_tag, disp_rs1_val,
           disp_rs2_wait, disp_rs2_tag, disp_rs2_val, disp_rd_tag, disp_op,
           disp_imm, disp_pc, cdb_valid, cdb_tag, cdb_val, iss_ready,
    output disp_ready, iss_valid, iss_op, iss_rs1_val, iss_rs2_val, iss_imm,
           iss_pc, iss_rd_tag, rs_full, rs_count
  );
endinterface

// File: rtl/rs_age_param_age_select.sv
// Module rs_age_select: an age matrix and an oldest-ready picker.
// r_age[i][j] = 1 means that entry j is older than entry i.
// Ports:
//   clk, rst  - clock, synchronous active-high clear
//   i_en      - update enable
//   i_busy    - busy vector at the start of the cycle
//   i_ready   - ready vector
//   i_alloc   - one-hot entry written this cycle
//   i_free    - one-hot entry issued this cycle
//   o_grant   - one-hot oldest ready entry
//   o_found   - some entry is ready
module rs_age_select #(
  parameter int DEPTH = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [DEPTH-1:0] i_busy,
  input  logic [DEPTH-1:0] i_ready,
  input  logic [DEPTH-1:0] i_alloc,
  input  logic [DEPTH-1:0] i_free,
  output logic [DEPTH-1:0] o_grant,
  output logic             o_found
);
  logic [DEPTH-1:0][DEPTH-1:0] r_age;

  // When an entry is allocated, every busy entry is older than it.
  // An entry that issues in the same cycle is excluded, because its column is cleared.
  always_ff @(posedge clk) begin
    if (rst) r_age <= '0;
    else if (i_en)
      for (int i = 0; i < DEPTH; i++)
        r_age[i] <= i_alloc[i] ? (i_busy & ~i_free) : (r_age[i] & ~i_free);
  end

  // The busy entries form a total order, so exactly one ready entry has no older ready entry.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < DEPTH; i++)
      o_grant[i] = i_ready[i] && !(|(r_age[i] & i_ready));
  end

  assign o_found = |i_ready;
endmodule

// File: rtl/rs_age_param.sv
// Module rs_age_param: reservation station between rename and the ALU.
// It holds DEPTH renamed ops and snoops NCDB broadcast channels to wake operands.
// It issues the oldest ready op through a registered valid/ready stage.
// Ports:
//   clk, rst - clock, synchronous active-high reset
//   bus      - rs_age_param_if.slave (dispatch, CDB, issue, status, rdy/flush)
// Optional macro RS_PERF_CNT_EN adds these saturating 32-bit outputs:
//   perf_full_cycles - cycles with disp_valid while the station is full
//   perf_issued      - issue handshakes
module rs_age_param
  import rs_age_param_pkg::*;
#(
  parameter int DEPTH  = RS_DEPTH,
  parameter int NCDB   = RS_NCDB,
  parameter int TAG_W  = RS_TAG_W,
  parameter int DATA_W = RS_DATA_W,
  parameter int OP_W   = RS_OP_W,
  parameter int IMM_W  = RS_IMM_W,
  parameter int PC_W   = RS_PC_W
)(
  input  logic clk,
  input  logic rst,
  rs_age_param_if.slave bus
`ifdef RS_PERF_CNT_EN
  ,
  output logic [31:0] perf_full_cycles,
  output logic [31:0] perf_issued
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic              busy;
    logic [OP_W-1:0]   op;
    logic              rs1_wait;
    logic [TAG_W-1:0]  rs1_tag;
    logic [DATA_W-1:0] rs1_val;
    logic              rs2_wait;
    logic [TAG_W-1:0]  rs2_tag;
    logic [DATA_W-1:0] rs2_val;
    logic [TAG_W-1:0]  rd_tag;
    logic [IMM_W-1:0]  imm;
    logic [PC_W-1:0]   pc;
  } entry_t;

  entry_t [DEPTH-1:0] r_ent;
  entry_t [DEPTH-1:0] w_nxt;
  entry_t             w_new;

  logic              r_iss_valid;
  logic [OP_W-1:0]   r_iss_op;
  logic [DATA_W-1:0] r_iss_rs1, r_iss_rs2;
  logic [IMM_W-1:0]  r_iss_imm;
  logic [PC_W-1:0]   r_iss_pc;
  logic [TAG_W-1:0]  r_iss_rd;
  logic [CNT_W-1:0]  r_count;

  logic [DEPTH-1:0]  w_busy, w_ready, w_alloc, w_grant, w_alloc_en, w_free_en;
  logic              w_found, w_disp, w_iss_load, w_clr, w_full;
  logic [OP_W-1:0]   w_sel_op;
  logic [DATA_W-1:0] w_sel_rs1, w_sel_rs2;
  logic [IMM_W-1:0]  w_sel_imm;
  logic [PC_W-1:0]   w_sel_pc;
  logic [TAG_W-1:0]  w_sel_rd;

  logic [NCDB-1:0]        w_cdb_valid;
  logic [NCDB*TAG_W-1:0]  w_cdb_tag;
  logic [NCDB*DATA_W-1:0] w_cdb_val;
  assign w_cdb_valid = bus.cdb_valid;
  assign w_cdb_tag   = bus.cdb_tag;
  assign w_cdb_val   = bus.cdb_val;

  // Returns {hit, value}. The loop scans downward, so the lowest matching channel wins.
  function automatic logic [DATA_W:0] cdb_match(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int c = NCDB - 1; c >= 0; c--)
      if (w_cdb_valid[c] && w_cdb_tag[c*TAG_W +: TAG_W] == tag)
        r = {1'b1, w_cdb_val[c*DATA_W +: DATA_W]};
    return r;
  endfunction

  always_comb begin
    w_busy = '0;
    w_ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_busy[i]  = r_ent[i].busy;
      w_ready[i] = r_ent[i].busy && !r_ent[i].rs1_wait && !r_ent[i].rs2_wait;
    end
  end

  // The lowest clear bit of busy gives the allocation slot.
  // It uses busy from the start of the cycle, so a slot freed by this cycle's issue is not reused yet.
  assign w_alloc        = ~w_busy & (w_busy + DEPTH'(1));
  assign w_full         = (r_count == CNT_W'(DEPTH));
  assign w_clr          = rst | bus.flush;
  assign w_disp         = bus.rdy & bus.disp_valid & ~&w_busy;
  assign w_iss_load     = bus.rdy & (~r_iss_valid | bus.iss_ready) & w_found;
  assign w_alloc_en     = w_disp ? w_alloc : '0;
  assign w_free_en      = w_iss_load ? w_grant : '0;

  rs_age_select #(.DEPTH(DEPTH)) u_age (
    .clk     (clk),
    .rst     (w_clr),
    .i_en    (bus.rdy),
    .i_busy  (w_busy),
    .i_ready (w_ready),
    .i_alloc (w_alloc_en),
    .i_free  (w_free_en),
    .o_grant (w_grant),
    .o_found (w_found)
  );

  always_comb begin
    w_sel_op = '0; w_sel_rs1 = '0; w_sel_rs2 = '0;
    w_sel_imm = '0; w_sel_pc = '0; w_sel_rd = '0;
    for (int i = 0; i < DEPTH; i++)
      if (w_grant[i]) begin
        w_sel_op  = r_ent[i].op;      w_sel_rs1 = r_ent[i].rs1_val;
        w_sel_rs2 = r_ent[i].rs2_val; w_sel_imm = r_ent[i].imm;
        w_sel_pc  = r_ent[i].pc;      w_sel_rd  = r_ent[i].rd_tag;
      end
  end

  // On dispatch, an operand that matches a same-cycle broadcast is stored already resolved.
  always_comb begin
    logic [DATA_W:0] b1, b2;
    b1 = cdb_match(bus.disp_rs1_tag);
    b2 = cdb_match(bus.disp_rs2_tag);
    w_new.busy     = 1'b1;
    w_new.op       = bus.disp_op;
    w_new.rs1_wait = bus.disp_rs1_wait & ~b1[DATA_W];
    w_new.rs1_tag  = bus.disp_rs1_tag;
    w_new.rs1_val  = (bus.disp_rs1_wait & b1[DATA_W]) ? b1[DATA_W-1:0] : bus.disp_rs1_val;
    w_new.rs2_wait = bus.disp_rs2_wait & ~b2[DATA_W];
    w_new.rs2_tag  = bus.disp_rs2_tag;
    w_new.rs2_val  = (bus.disp_rs2_wait & b2[DATA_W]) ? b2[DATA_W-1:0] : bus.disp_rs2_val;
    w_new.rd_tag   = bus.disp_rd_tag;
    w_new.imm      = bus.disp_imm;
    w_new.pc       = bus.disp_pc;
  end

  // Each operand wakes independently. The issuing entry is freed, and the allocated slot is overwritten.
  always_comb begin
    logic [DATA_W:0] m1, m2;
    w_nxt = r_ent;
    m1 = '0;
    m2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m1 = cdb_match(r_ent[i].rs1_tag);
      m2 = cdb_match(r_ent[i].rs2_tag);
      if (r_ent[i].rs1_wait && m1[DATA_W]) begin
        w_nxt[i].rs1_wait = 1'b0;
        w_nxt[i].rs1_val  = m1[DATA_W-1:0];
      end
      if (r_ent[i].rs2_wait && m2[DATA_W]) begin
        w_nxt[i].rs2_wait = 1'b0;
        w_nxt[i].rs2_val  = m2[DATA_W-1:0];
      end
      if (w_free_en[i])  w_nxt[i].busy = 1'b0;
      if (w_alloc_en[i]) w_nxt[i] = w_new;
    end
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i].busy <= 1'b0;
      r_iss_valid <= 1'b0;
      r_iss_op <= '0; r_iss_rs1 <= '0; r_iss_rs2 <= '0;
      r_iss_imm <= '0; r_iss_pc <= '0; r_iss_rd <= '0;
      r_count <= '0;
    end else if (bus.rdy) begin
      r_ent <= w_nxt;
      if (w_iss_load) begin
        r_iss_valid <= 1'b1;
        r_iss_op  <= w_sel_op;  r_iss_rs1 <= w_sel_rs1; r_iss_rs2 <= w_sel_rs2;
        r_iss_imm <= w_sel_imm; r_iss_pc  <= w_sel_pc;  r_iss_rd  <= w_sel_rd;
      end else if (bus.iss_ready) begin
        r_iss_valid <= 1'b0;
      end
      r_count <= r_count + CNT_W'(w_disp) - CNT_W'(w_iss_load);
    end
  end

  assign bus.disp_ready  = ~&w_busy;
  assign bus.iss_valid   = r_iss_valid;
  assign bus.iss_op      = r_iss_op;
  assign bus.iss_rs1_val = r_iss_rs1;
  assign bus.iss_rs2_val = r_iss_rs2;
  assign bus.iss_imm     = r_iss_imm;
  assign bus.iss_pc      = r_iss_pc;
  assign bus.iss_rd_tag  = r_iss_rd;
  assign bus.rs_full     = w_full;
  assign bus.rs_count    = r_count;

`ifdef RS_PERF_CNT_EN
  logic [31:0] r_perf_full, r_perf_iss;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_full <= '0;
      r_perf_iss  <= '0;
    end else if (bus.rdy) begin
      if (bus.disp_valid && w_full && r_perf_full != '1) r_perf_full <= r_perf_full + 32'd1;
      if (r_iss_valid && bus.iss_ready && r_perf_iss != '1) r_perf_iss <= r_perf_iss + 32'd1;
    end
  end
  assign perf_full_cycles = r_perf_full;
  assign perf_issued      = r_perf_iss;
`endif
endmodule
